tile_line_buffer: RTL and testbench

//  Ping-pong line buffer and line-fill sequencer downstream of the tile engine.
//  - Issues one tile_start pulse per scanline.
//  - Captures the 40 tile rows (16 px each) produced for the next line into the write bank.
//  - Streams the read bank to the VGA output one pixel per clock, indexed by hcount.

---
 rtl/tile_line_buffer.sv | 119 +++++++++++
 tb/tb_tile_line_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_line_buffer.sv
// Ping-pong scanline buffer: captures tile rows from the tile engine into the write bank
// and streams the read bank to the VGA output stage one pixel per clock.
module tile_line_buffer #(
  parameter int unsigned PIX_W    = 16,
  parameter int unsigned TILE_PX  = 16,
  parameter int unsigned COLS     = 40,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned START_H  = 640
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [9:0]                 hcount,
  input  logic [9:0]                 vcount,
  output logic                       tile_start,
  input  logic                       tile_valid,
  input  logic [5:0]                 tile_col,
  input  logic [TILE_PX*PIX_W-1:0]   tile_data,
  input  logic                       tile_done,
  output logic [PIX_W-1:0]           pix_out,
  output logic                       pix_valid,
  output logic                       underrun
);

  localparam int unsigned WORD_W = TILE_PX * PIX_W;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned SEL_W  = $clog2(TILE_PX);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             wr_bank;
  logic [COL_W-1:0] fill_cnt;
  logic             tile_done_q;

  logic [WORD_W-1:0] mem [2][COLS];
  logic [WORD_W-1:0] word_q;
  logic [SEL_W-1:0]  sel_q;
  logic              act_q;

  logic             swap_c;
  logic             fill_full_c;
  logic             done_rise_c;
  logic             wr_en_c;
  logic             active_c;
  logic [COL_W-1:0] rd_col_c;

  assign swap_c      = (hcount == 10'(START_H));
  assign fill_full_c = (fill_cnt == COL_W'(COLS));
  assign done_rise_c = tile_done & ~tile_done_q;
  assign wr_en_c     = reset_n & tile_valid & (state == ST_FILL) &
                       (tile_col < COL_W'(COLS)) & ~swap_c;
  assign active_c    = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign rd_col_c    = (COL_W'(hcount >> SEL_W) < COL_W'(COLS)) ? COL_W'(hcount >> SEL_W) : '0;

  // Fill sequencer next state; every swap (re)starts a fill
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (swap_c) state_nxt = ST_FILL;
      ST_FILL: begin
        if (swap_c) state_nxt = ST_FILL;
        else if (fill_full_c || (done_rise_c && fill_full_c)) state_nxt = ST_DONE;
      end
      ST_DONE: if (swap_c) state_nxt = ST_FILL;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wr_bank     <= 1'b0;
      fill_cnt    <= '0;
      tile_start  <= 1'b0;
      underrun    <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      tile_start  <= swap_c;
      tile_done_q <= tile_done;
      if (swap_c) begin
        wr_bank  <= ~wr_bank;
        fill_cnt <= '0;
        // A fill that never started (first line after reset) is not an underrun
        if ((state != ST_IDLE) && ((state == ST_FILL) || !fill_full_c)) underrun <= 1'b1;
      end else if (wr_en_c && !fill_full_c) begin
        fill_cnt <= fill_cnt + COL_W'(1);
      end
    end
  end

  // Bank storage is never cleared
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_bank][tile_col] <= tile_data;
  end

  always_ff @(posedge clk) begin
    word_q <= mem[~wr_bank][rd_col_c];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q     <= '0;
      act_q     <= 1'b0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      sel_q     <= hcount[SEL_W-1:0];
      act_q     <= active_c;
      pix_out   <= act_q ? word_q[sel_q*PIX_W +: PIX_W] : '0;
      pix_valid <= act_q;
    end
  end

endmodule

// File: tb/tb_tile_line_buffer.sv
// Randomized scoreboard bench for tile_line_buffer: a pixel-array reference model predicts
// tile_start/underrun one cycle out and pix_out/pix_valid two cycles out.
module tb_tile_line_buffer;

  localparam int unsigned PIX_W   = 16;
  localparam int unsigned TILE_PX = 16;
  localparam int unsigned COLS    = 40;
  localparam int unsigned WORD_W  = PIX_W * TILE_PX;
  localparam int          H_TOTAL = 800;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              tile_start;
  logic              tile_valid;
  logic [5:0]        tile_col;
  logic [WORD_W-1:0] tile_data;
  logic              tile_done;
  logic [PIX_W-1:0]  pix_out;
  logic              pix_valid;
  logic              underrun;

  tile_line_buffer dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .tile_start(tile_start), .tile_valid(tile_valid), .tile_col(tile_col),
    .tile_data(tile_data), .tile_done(tile_done), .pix_out(pix_out),
    .pix_valid(pix_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned due; logic [PIX_W-1:0] pix; logic vld; bit known; } pix_e_t;
  typedef struct { int unsigned due; logic start; logic und; } ctl_e_t;
  typedef struct { logic [5:0] col; logic [WORD_W-1:0] data; } wr_t;

  pix_e_t pix_q[$];
  ctl_e_t ctl_q[$];
  wr_t    plan_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: each bank as a flat array of 640 pixels
  logic [PIX_W-1:0] mbank [2][640];
  bit               mknown[2][640];
  bit m_wr, m_started, m_under;
  int m_cnt;

  int h, v, rst_left, fill_idx, cur_fill, ok_cnt;
  bit reset_done_mid;

  task automatic build_plan(input int f);
    int order[$];
    wr_t e;
    int n, j, tmp, junk;
    plan_q.delete();
    n = (f == 3) ? 20 : 40;
    for (int c = 0; c < 40; c++) order.push_back(c);
    if (f != 0 && f != 3) begin
      for (int i = 39; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
    end
    for (int k = 0; k < n; k++) begin
      e.col = 6'(order[k]);
      for (int i = 0; i < 16; i++) begin
        case (f)
          0:       e.data[i*16 +: 16] = 16'(order[k] * 16 + i);
          1:       e.data[i*16 +: 16] = 16'h1111;
          2:       e.data[i*16 +: 16] = 16'h2222;
          default: e.data[i*16 +: 16] = 16'($urandom);
        endcase
      end
      plan_q.push_back(e);
    end
    if (f == 4) plan_q[39].col = plan_q[0].col;
    junk = (f == 4) ? 3 : ((f >= 6) ? 2 : 0);
    for (int k = 0; k < junk; k++) begin
      e.col = 6'($urandom_range(40, 63));
      e.data = {8{32'($urandom)}};
      plan_q.insert($urandom_range(0, plan_q.size()), e);
    end
  endtask

  task automatic drive_cycle();
    bit rst, tv, act;
    logic [5:0] col;
    logic [WORD_W-1:0] data;
    wr_t e;
    pix_e_t pe;
    ctl_e_t ce;
    bit rd;

    rst = (rst_left == 0);
    if (rst_left > 0) rst_left--;
    tv = 1'b0;
    col = '0;
    data = '0;
    if (!rst) begin
      plan_q.delete();
      tv = 1'($urandom);
      col = 6'($urandom_range(0, 39));
      data = {8{32'($urandom)}};
    end else if (h == 640) begin
      tv = 1'b1;
      col = 6'($urandom_range(0, 39));
      data = {8{32'($urandom)}};
    end else if (h >= 642 && plan_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      e = plan_q.pop_front();
      tv = 1'b1;
      col = e.col;
      data = e.data;
    end

    reset_n    = rst;
    hcount     = 10'(h);
    vcount     = 10'(v);
    tile_valid = tv;
    tile_col   = col;
    tile_data  = data;
    tile_done  = (plan_q.size() == 0);

    // Expected pixel: read bank is the one not being written at the moment of the read
    rd = ~m_wr;
    act = (h < 640) && (v < 480);
    if (!rst) begin
      foreach (pix_q[i]) if (pix_q[i].due >= cyc + 1) begin
        pix_q[i].pix = '0; pix_q[i].vld = 1'b0; pix_q[i].known = 1'b1;
      end
      pe = '{due: cyc + 2, pix: '0, vld: 1'b0, known: 1'b1};
    end else if (act) begin
      pe = '{due: cyc + 2, pix: mbank[rd][h], vld: 1'b1, known: mknown[rd][h]};
    end else begin
      pe = '{due: cyc + 2, pix: '0, vld: 1'b0, known: 1'b1};
    end
    pix_q.push_back(pe);

    ce.due = cyc + 1;
    if (!rst) begin
      m_wr = 0; m_started = 0; m_cnt = 0; m_under = 0;
      ce.start = 1'b0;
    end else if (h == 640) begin
      ce.start = 1'b1;
      if (m_started && m_cnt != 40) m_under = 1;
      m_wr = ~m_wr;
      m_started = 1;
      m_cnt = 0;
      cur_fill = fill_idx;
      ok_cnt = 0;
      build_plan(fill_idx);
      fill_idx++;
    end else begin
      ce.start = 1'b0;
      if (tv && m_started && m_cnt < 40 && col < 40) begin
        for (int i = 0; i < 16; i++) begin
          mbank[m_wr][int'(col) * 16 + i]  = data[i*16 +: 16];
          mknown[m_wr][int'(col) * 16 + i] = 1;
        end
        m_cnt++;
        ok_cnt++;
        if (cur_fill == 5 && ok_cnt == 20 && !reset_done_mid) begin
          rst_left = 5;
          reset_done_mid = 1;
        end
      end
    end
    ce.und = m_under;
    ctl_q.push_back(ce);

    h++;
    if (h == H_TOTAL) begin
      h = 0;
      v++;
    end
  endtask

  initial begin
    h = 630; v = 470; rst_left = 5; fill_idx = 0; cur_fill = -1; ok_cnt = 0;
    reset_done_mid = 0;
    m_wr = 0; m_started = 0; m_cnt = 0; m_under = 0;
    foreach (mknown[b, p]) mknown[b][p] = 0;
    drive_cycle();
    while (v < 485) begin
      @(posedge clk);
      #1;
      drive_cycle();
    end
    repeat (4) @(posedge clk);
    #7;
    if (pix_q.size() != 0 || ctl_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pix_left=%0d ctl_left=%0d required=0", pix_q.size(), ctl_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compares DUT outputs against entries whose due cycle has arrived
  initial begin
    ctl_e_t c;
    pix_e_t p;
    forever begin
      @(negedge clk);
      while (ctl_q.size() > 0 && ctl_q[0].due <= cyc) begin
        c = ctl_q.pop_front();
        total++;
        if (tile_start !== c.start) begin
          bad++;
          $display("FAIL tile_start cyc=%0d got=%b exp=%b", cyc, tile_start, c.start);
        end
        total++;
        if (underrun !== c.und) begin
          bad++;
          $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, underrun, c.und);
        end
      end
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        p = pix_q.pop_front();
        total++;
        if (pix_valid !== p.vld) begin
          bad++;
          $display("FAIL pix_valid cyc=%0d got=%b exp=%b", cyc, pix_valid, p.vld);
        end
        if (p.known) begin
          total++;
          if (pix_out !== p.pix) begin
            bad++;
            $display("FAIL pix_out cyc=%0d got=%h exp=%h", cyc, pix_out, p.pix);
          end
        end
      end
    end
  end

endmodule
